fifo_64_rd_stream: RTL
======================

# fifo_64_rd_stream

Read-side adapter for the 64-bit non-showahead FIFOs (1-cycle read latency, registered `valid`). Drains the FIFO through a 2-entry skid buffer and presents a valid/ready stream with packet framing (`m_last` every PKT_LEN beats). Sits between a FIFO's read port and any downstream consumer that may stall; sustains one word per cycle while `m_ready` is high.

## Interface
- WIDTH, 64, data width of FIFO and stream
- PKT_LEN, 8, beats per packet (≥1); `m_last` marks beat PKT_LEN-1
- clk  in  1  sole clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- fifo_rd_en  out  1  read request to FIFO
- fifo_dout  in  WIDTH  FIFO read data, meaningful when `fifo_valid`=1
- fifo_empty  in  1  FIFO empty flag
- fifo_valid  in  1  FIFO data valid, one cycle after accepted read
- m_data  out  WIDTH  stream data (head of skid buffer)
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready from consumer
- m_last  out  1  last beat of current packet
- beat_cnt  out  32  total beats accepted downstream, wraps at 2^32
- err_ovf  out  1  sticky: `fifo_valid` arrived with no pending read or no free entry

## Operation
- State: `occ` (0..2 entries held), `pend` (read issued last cycle, data due now), 2×WIDTH buffer (head/tail), packet counter `pcnt` (ceil(log2(PKT_LEN)) bits, min 1), `beat_cnt`, `err_ovf`.
- Pop: `pop = m_valid & m_ready`.
- Free-slot credit: `free = 2 - occ - pend + pop`.
- `fifo_rd_en = ~fifo_empty & (free >= 1)`; held 0 while rst_n=0.
- `pend` next = `fifo_rd_en & ~fifo_empty`.
- Push: when `fifo_valid`=1, `fifo_dout` written to tail (to head if occ=0 or occ=1 with pop). Push and pop in same cycle: occ unchanged, tail shifts to head.
- `m_valid = (occ != 0)`; `m_data` = head register (zero when occ=0 after reset; otherwise holds last contents).
- Stream rule: `m_data`/`m_last` stable while `m_valid & ~m_ready`.
- `m_last = m_valid & (pcnt == PKT_LEN-1)`; on pop `pcnt` increments, wraps to 0 after PKT_LEN-1. PKT_LEN=1: `m_last` = `m_valid`.
- `beat_cnt` increments by 1 on each pop.
- `err_ovf` set when `fifo_valid & ~pend`, or `fifo_valid` with occ=2 and no pop; cleared only by reset. On overflow the word is dropped; occ saturates at 2.

## Timing
- Reset (async assert, sync-safe deassert by system): occ=0, pend=0, pcnt=0, buffer=0, beat_cnt=0, err_ovf=0 → `m_valid`=0, `m_last`=0, `m_data`=0, `fifo_rd_en`=0.
- Latency: FIFO non-empty at cycle N (module idle) → `fifo_rd_en`=1 at N → `fifo_valid` at N+1 → `m_valid`=1 at N+2.
- Throughput: steady state occ=1, pend=1, `m_ready`=1 → `fifo_rd_en` every cycle, one beat per cycle.
- Stall: `m_ready`=0 → at most 2 words buffered; `fifo_rd_en` deasserts once occ+pend=2; no word lost.
- Stall release: first pop cycle re-enables `fifo_rd_en` same cycle (combinational on `m_ready`).
- `fifo_empty` rising mid-stream: no new reads; buffered words still delivered.
- Reset mid-packet: buffered/pending words discarded, `pcnt` restarts at 0.

## Test plan
- Reset: assert rst_n=0 with FIFO holding data → `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `beat_cnt`=0 throughout reset.
- Streaming: load 16 words 0..15, `m_ready`=1 → first `m_valid` 2 cycles after first `fifo_rd_en`, 16 consecutive beats 0..15, `m_last` on words 7 and 15, `beat_cnt`=16.
- Backpressure: 16 words, `m_ready` random 50% → output order 0..15 exact, never >2 buffered, `err_ovf`=0, `m_data` stable during every stall.
- Full stall: `m_ready`=0 for 20 cycles with 10 words queued → exactly 2 `fifo_rd_en` pulses, `m_data`=0 held; release → words 0..9 in order.
- Spurious valid: inject `fifo_valid`=1 with no preceding read → `err_ovf`=1 next cycle and stays until reset.
- PKT_LEN=1 and PKT_LEN=3: 6 words → `m_last` on every beat, resp. beats 2 and 5; reset after beat 1 → next packet's `m_last` on its third beat.

Source files
------------

// File: rtl/fifo_64_rd_stream.sv
// fifo_64_rd_stream
// Read-side adapter for a non-showahead FIFO with 1-cycle read latency.
// Drains the FIFO into a 2-entry skid buffer and presents a valid/ready
// stream, framed into packets of PKT_LEN beats using m_last.
//
// Handshake: a beat transfers on any rising clk edge where m_valid and
// m_ready are both high. While m_valid is high and m_ready is low, m_data
// and m_last hold their values. m_valid never drops without a transfer.
module fifo_64_rd_stream #(
   parameter int WIDTH   = 64,
   parameter int PKT_LEN = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_dout,
   input  logic             fifo_empty,
   input  logic             fifo_valid,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic [31:0]      beat_cnt,
   output logic             err_ovf
);

   localparam int            PW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [PW-1:0] PCNT_MAX = PW'(PKT_LEN - 1);

   logic [1:0]       occ;      // entries held in the skid buffer (0..2)
   logic             pend;     // read issued last cycle, data due this cycle
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic [PW-1:0]    pcnt;

   logic       pop;
   logic       push;
   logic       ovf;
   logic [2:0] used;
   logic [2:0] avail;

   assign m_valid = (occ != 2'd0);
   assign m_data  = head_q;
   assign m_last  = m_valid & (pcnt == PCNT_MAX);

   // Credit check: a read may issue only if a slot is guaranteed when its
   // data returns, counting a pop this cycle as a freed slot.
   always_comb begin
      pop        = m_valid & m_ready;
      used       = {1'b0, occ} + {2'b00, pend};
      avail      = 3'd2 + {2'b00, pop};
      fifo_rd_en = rst_n & ~fifo_empty & (used < avail);
      ovf        = fifo_valid & (~pend | ((occ == 2'd2) & ~pop));
      push       = fifo_valid & ~ovf;
   end

   // Skid buffer: head is always the oldest word; tail shifts in on pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ    <= 2'd0;
         pend   <= 1'b0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         pend <= fifo_rd_en & ~fifo_empty;
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) head_q <= fifo_dout;
               else             tail_q <= fifo_dout;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               if (occ == 2'd2) head_q <= tail_q;
               occ <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd2) begin
                  head_q <= tail_q;
                  tail_q <= fifo_dout;
               end else begin
                  head_q <= fifo_dout;
               end
            end
            default: ;
         endcase
      end
   end

   // Packet position and running beat count advance on each transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt     <= '0;
         beat_cnt <= 32'd0;
      end else if (pop) begin
         pcnt     <= (pcnt == PCNT_MAX) ? '0 : pcnt + PW'(1);
         beat_cnt <= beat_cnt + 32'd1;
      end
   end

   // Sticky overflow flag: unexpected or unplaceable read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_ovf <= 1'b0;
      else if (ovf) err_ovf <= 1'b1;
   end

endmodule
